// File: rtl/mbc_sequencer.sv
// mbc_sequencer: serial MBC pattern generator armed by Arm and fired by address match A_5 (SClk, nReset active-low sync; Cfg* load pattern/len; MBC/MBCSeqStart/Busy/Done out)
module mbc_sequencer #(
  parameter logic [23:0] DEF_PATTERN = 24'h028A07,
  parameter int          DEF_LEN     = 21
) (
  input  logic        SClk,
  input  logic        nReset,
  input  logic [7:0]  AddrLo,
  input  logic [3:0]  AddrHi,
  input  logic        Arm,
  input  logic        Abort,
  input  logic        CfgWe,
  input  logic [23:0] CfgPattern,
  input  logic [4:0]  CfgLen,
  output logic        MBC,
  output logic        MBCSeqStart,
  output logic        Busy,
  output logic        Done
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0]  state;
  logic [4:0]  idx, len, nxt;
  logic [23:0] pat;
  logic        match, idle_like, last;
  assign match     = AddrLo[3:0] == 4'h5 && AddrHi == 4'hA;
  assign idle_like = state == IDLE || state == DONE;
  assign last      = idx == len - 5'd1;
  assign nxt       = idx + 5'd1;
  always_ff @(posedge SClk) begin
    if (!nReset) begin
      state       <= IDLE;
      idx         <= 5'd0;
      pat         <= DEF_PATTERN;
      len         <= 5'(DEF_LEN);
      MBC         <= 1'b1;
      MBCSeqStart <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      MBCSeqStart <= 1'b0;
      if (Abort && !idle_like) begin
        state <= IDLE;
        MBC   <= 1'b1;
        Busy  <= 1'b0;
        Done  <= 1'b0;
      end else if (state == ARMED) begin
        if (match) begin
          state       <= SHIFT;
          idx         <= 5'd0;
          MBC         <= pat[0];
          MBCSeqStart <= 1'b1;
        end
      end else if (state == SHIFT) begin
        if (last) begin
          state <= DONE;
          MBC   <= 1'b1;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end else begin
          idx <= nxt;
          MBC <= pat[nxt];
        end
      end else begin
        if (CfgWe) begin
          pat <= CfgPattern;
          if (CfgLen != 5'd0) len <= (CfgLen > 5'd24) ? 5'd24 : CfgLen;
        end
        if (Arm) begin
          state <= ARMED;
          Busy  <= 1'b1;
          Done  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mbc_sequencer.sv
// tb_mbc_sequencer: directed and random stimulus scored against a queue-based behavioural model
module tb_mbc_sequencer;
  logic        SClk = 1'b0;
  logic        nReset = 1'b0;
  logic [7:0]  AddrLo = 8'h00;
  logic [3:0]  AddrHi = 4'h0;
  logic        Arm = 1'b0, Abort = 1'b0, CfgWe = 1'b0;
  logic [23:0] CfgPattern = 24'h0;
  logic [4:0]  CfgLen = 5'd0;
  logic        MBC, MBCSeqStart, Busy, Done;
  int          checks = 0, passed = 0;
  logic [3:0]  exp_q[$];
  logic        m_armed, m_shift, m_done, m_bit, m_start;
  logic        m_rem[$];
  logic [23:0] m_pat;
  int          m_len;
  bit          drv_done = 0;

  mbc_sequencer dut (
    .SClk(SClk), .nReset(nReset), .AddrLo(AddrLo), .AddrHi(AddrHi), .Arm(Arm), .Abort(Abort),
    .CfgWe(CfgWe), .CfgPattern(CfgPattern), .CfgLen(CfgLen),
    .MBC(MBC), .MBCSeqStart(MBCSeqStart), .Busy(Busy), .Done(Done)
  );

  always #5 SClk = ~SClk;

  task automatic model_step(input logic r, a, ab, m, w, input logic [23:0] p, input logic [4:0] l);
    if (!r) begin
      m_armed = 0; m_shift = 0; m_done = 0; m_bit = 1; m_start = 0;
      m_rem.delete();
      m_pat = 24'h028A07; m_len = 21;
    end else begin
      m_start = 0;
      if ((m_armed || m_shift) && ab) begin
        m_armed = 0; m_shift = 0; m_done = 0;
        m_rem.delete();
      end else if (m_shift) begin
        if (m_rem.size() == 0) begin
          m_shift = 0; m_done = 1;
        end else m_bit = m_rem.pop_front();
      end else if (m_armed) begin
        if (m) begin
          for (int k = 0; k < m_len; k++) m_rem.push_back(m_pat[k]);
          m_bit = m_rem.pop_front();
          m_start = 1; m_shift = 1; m_armed = 0;
        end
      end else begin
        if (w) begin
          m_pat = p;
          if (l != 0) m_len = (l > 24) ? 24 : int'(l);
        end
        if (a) begin
          m_armed = 1; m_done = 0;
        end
      end
    end
    exp_q.push_back({m_shift ? m_bit : 1'b1, m_start, m_armed || m_shift, m_done});
  endtask

  task automatic cyc(input logic r, a, ab, m, w, input logic [23:0] p, input logic [4:0] l);
    logic [3:0] hi;
    @(negedge SClk);
    nReset = r; Arm = a; Abort = ab; CfgWe = w; CfgPattern = p; CfgLen = l;
    if (m) begin
      AddrLo = {4'($urandom), 4'h5};
      AddrHi = 4'hA;
    end else begin
      AddrLo = 8'($urandom);
      hi = 4'($urandom);
      AddrHi = (AddrLo[3:0] == 4'h5 && hi == 4'hA) ? 4'hB : hi;
    end
    model_step(r, a, ab, m, w, p, l);
  endtask

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, m, 0, 24'h0, 5'd0);
  endtask

  initial begin : monitor
    logic [3:0] e, got;
    forever begin
      @(posedge SClk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {MBC, MBCSeqStart, Busy, Done};
        checks++;
        if (got === e) passed++;
        else $display("FAIL outputs t=%0t {MBC,Start,Busy,Done} got=%b exp=%b", $time, got, e);
      end
    end
  end

  initial begin : driver
    cyc(0, 0, 0, 0, 0, 24'h0, 5'd0);
    cyc(0, 1, 1, 1, 1, 24'h123456, 5'd7);
    idle(2, 0);
    cyc(1, 1, 0, 0, 0, 24'h0, 5'd0);
    idle(2, 0);
    idle(1, 1);
    idle(26, 0);
    cyc(1, 0, 0, 0, 1, 24'hFFFFF0, 5'd30);
    cyc(1, 1, 0, 0, 0, 24'h0, 5'd0);
    idle(1, 1);
    idle(28, 0);
    cyc(0, 0, 0, 0, 0, 24'h0, 5'd0);
    cyc(1, 1, 1, 1, 0, 24'h0, 5'd0);
    idle(6, 1);
    cyc(1, 1, 0, 1, 0, 24'h0, 5'd0);
    idle(20, 1);
    cyc(1, 1, 0, 0, 0, 24'h0, 5'd0);
    idle(1, 1);
    idle(7, 0);
    cyc(1, 0, 1, 0, 0, 24'h0, 5'd0);
    idle(5, 1);
    cyc(1, 0, 0, 0, 1, 24'hABCDEF, 5'd5);
    cyc(1, 1, 0, 0, 0, 24'h0, 5'd0);
    idle(1, 1);
    idle(2, 0);
    cyc(0, 0, 0, 1, 0, 24'h0, 5'd0);
    cyc(1, 1, 0, 0, 0, 24'h0, 5'd0);
    idle(1, 1);
    idle(25, 0);
    cyc(1, 1, 0, 0, 0, 24'h0, 5'd0);
    cyc(1, 0, 0, 0, 1, 24'h000001, 5'd3);
    idle(1, 1);
    idle(25, 0);
    cyc(1, 1, 0, 0, 0, 24'h0, 5'd0);
    idle(1, 1);
    idle(25, 0);
    cyc(1, 0, 0, 0, 1, 24'h5A5A5A, 5'd1);
    cyc(1, 1, 0, 0, 1, 24'h000003, 5'd0);
    idle(1, 1);
    idle(4, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 24'($urandom), 5'($urandom));
    idle(3, 0);
    drv_done = 1;
  end

  initial begin : finisher
    int guard;
    guard = 0;
    while (!(drv_done && exp_q.size() == 0) && guard < 20000) begin
      @(negedge SClk);
      guard++;
    end
    if (guard >= 20000) begin
      checks++;
      $display("FAIL timeout pending=%0d required=0", exp_q.size());
    end
    @(negedge SClk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
